// File: rtl/nrst_sequencer_if.sv
// Sequencer status/control bundle: SW reset request in, sequenced resets and status out.
// The master side is the sequencer; the slave side is the reset consumer or observer.
interface nrst_sequencer_if #(
    parameter int NUM_OUTS = 3
);
    logic                srst_i;
    logic [NUM_OUTS-1:0] nrst_o;
    logic                done_o;
    logic [1:0]          state_o;

    modport master (
        input  srst_i,
        output nrst_o,
        output done_o,
        output state_o
    );

    modport slave (
        output srst_i,
        input  nrst_o,
        input  done_o,
        input  state_o
    );
endinterface

// File: rtl/nrst_sequencer.sv
// Reset sequencer: sync NRST_I, hold HOLD_CYCLES, release NRST_O bits STEP_CYCLES apart; all outputs are flops.
// No backpressure; define RST_SEQ_SW_RESET_EN to let a synchronous SRST_I request re-run the hold/release sequence.
module nrst_sequencer #(
    parameter int STAGES      = 2,
    parameter int NUM_OUTS    = 3,
    parameter int HOLD_CYCLES = 4,
    parameter int STEP_CYCLES = 3
) (
    input  logic             CLK_I,
    input  logic             NRST_I,
    nrst_sequencer_if.master bus
);
    localparam int MAXC = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int IW   = $clog2(NUM_OUTS + 1);

    localparam logic [CW-1:0] HOLD_C = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] STEP_C = CW'(STEP_CYCLES);
    localparam logic [IW-1:0] LAST_I = IW'(NUM_OUTS);

    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } state_t;

    logic [STAGES-1:0]   sync_q,  sync_d;
    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q,   cnt_d;
    logic [IW-1:0]       idx_q,   idx_d;
    logic [NUM_OUTS-1:0] nrst_q,  nrst_d;
    logic                done_q,  done_d;

    logic [CW-1:0]       cnt_inc;
    logic                synced;
    logic                sw_req;

    assign synced  = sync_q[STAGES-1];
    // Saturating increment: the counter is cleared on every release, so it never
    // needs to wrap, and holding at all-ones keeps a stuck count harmless.
    assign cnt_inc = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + 1'b1;

`ifdef RST_SEQ_SW_RESET_EN
    // In SYNC the synchronized board reset still owns the sequence.
    assign sw_req = bus.srst_i && (state_q != SYNC);
`else
    logic unused_srst;
    assign unused_srst = bus.srst_i;
    assign sw_req      = 1'b0;
`endif

    always_comb begin
        sync_d  = {sync_q[STAGES-2:0], 1'b1};
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        nrst_d  = nrst_q;
        done_d  = done_q;

        unique case (state_q)
            SYNC: begin
                // The edge that first sees the synced release is also the first hold count.
                if (synced) begin
                    if (HOLD_C == CW'(1)) begin
                        nrst_d[0] = 1'b1;
                        idx_d     = IW'(1);
                        cnt_d     = '0;
                        state_d   = RELEASE;
                    end else begin
                        cnt_d   = CW'(1);
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (cnt_inc == HOLD_C) begin
                    nrst_d[0] = 1'b1;
                    idx_d     = IW'(1);
                    cnt_d     = '0;
                    state_d   = RELEASE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RELEASE: begin
                if (idx_q == LAST_I) begin
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = RUN;
                end else if (cnt_inc == STEP_C) begin
                    for (int k = 0; k < NUM_OUTS; k++) begin
                        if (IW'(k) == idx_q) begin
                            nrst_d[k] = 1'b1;
                        end
                    end
                    idx_d = idx_q + 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = SYNC;
            end
        endcase

        // While the request stays high this re-enters HOLD every edge with the count at zero.
        if (sw_req) begin
            nrst_d  = '0;
            done_d  = 1'b0;
            cnt_d   = '0;
            idx_d   = '0;
            state_d = HOLD;
        end
    end

    always_ff @(posedge CLK_I or negedge NRST_I) begin
        if (!NRST_I) begin
            sync_q  <= '0;
            state_q <= SYNC;
            cnt_q   <= '0;
            idx_q   <= '0;
            nrst_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            nrst_q  <= nrst_d;
            done_q  <= done_d;
        end
    end

    assign bus.nrst_o  = nrst_q;
    assign bus.done_o  = done_q;
    assign bus.state_o = state_q;
endmodule
